seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider (DIV, DIVU, REM, REMU) using restoring division.
// Constant latency: one quotient bit per cycle, sign fix-up and special cases in FIX.
module seq_divider #(
  parameter int NUM_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [NUM_SIZE-1:0] dividend,
  input  logic [NUM_SIZE-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic [NUM_SIZE-1:0] result
);

  localparam int                   CNT_W     = $clog2(NUM_SIZE + 1);
  localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(NUM_SIZE - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [NUM_SIZE-1:0]  ONE       = NUM_SIZE'(1);
  localparam logic [NUM_SIZE-1:0]  MOST_NEG  = {1'b1, {(NUM_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, DIVIDE, FIX, DONE} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [1:0]          r_op;
  logic [NUM_SIZE-1:0] r_dividend;
  logic [NUM_SIZE-1:0] r_divisor;
  logic [NUM_SIZE-1:0] r_dvsMag;
  logic [NUM_SIZE-1:0] r_quot;
  logic [NUM_SIZE-1:0] r_rem;
  logic [NUM_SIZE-1:0] r_result;
  logic [CNT_W-1:0]    r_count;
  logic                r_negQ;
  logic                r_negR;
  logic                r_fixPhase;

  logic                w_signed;
  logic                w_selRem;
  logic                w_dvdNeg;
  logic                w_dvsNeg;
  logic [NUM_SIZE:0]   w_remShift;
  logic [NUM_SIZE:0]   w_diff;
  logic                w_borrow;
  logic                w_divZero;
  logic                w_overflow;
  logic [NUM_SIZE-1:0] w_selected;

  assign w_signed   = ~r_op[0];
  assign w_selRem   = r_op[1];
  assign w_dvdNeg   = w_signed & r_dividend[NUM_SIZE-1];
  assign w_dvsNeg   = w_signed & r_divisor[NUM_SIZE-1];

  // r_quot doubles as the dividend shift register: its MSB feeds the remainder
  assign w_remShift = {r_rem, r_quot[NUM_SIZE-1]};
  assign w_diff     = w_remShift - {1'b0, r_dvsMag};
  assign w_borrow   = w_diff[NUM_SIZE];

  assign w_divZero  = (r_divisor == '0);
  assign w_overflow = w_signed && (r_dividend == MOST_NEG) && (r_divisor == '1);

  always_comb begin
    w_selected = w_selRem ? r_rem : r_quot;
    if (w_divZero) begin
      w_selected = w_selRem ? r_dividend : '1;
    end else if (w_overflow) begin
      w_selected = w_selRem ? '0 : r_dividend;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_nextState = PREP;
      end
      PREP: begin
        busy        = 1'b1;
        w_nextState = DIVIDE;
      end
      DIVIDE: begin
        busy = 1'b1;
        if (r_count == LAST_ITER) w_nextState = FIX;
      end
      FIX: begin
        busy = 1'b1;
        if (r_fixPhase) w_nextState = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // FIX spends one cycle on sign correction and a second on selection into result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_dvsMag   <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_result   <= '0;
      r_count    <= '0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_fixPhase <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op       <= op;
            r_dividend <= dividend;
            r_divisor  <= divisor;
          end
        end
        PREP: begin
          r_quot     <= w_dvdNeg ? (~r_dividend + ONE) : r_dividend;
          r_dvsMag   <= w_dvsNeg ? (~r_divisor + ONE) : r_divisor;
          r_rem      <= '0;
          r_negQ     <= w_dvdNeg ^ w_dvsNeg;
          r_negR     <= w_dvdNeg;
          r_count    <= '0;
          r_fixPhase <= 1'b0;
        end
        DIVIDE: begin
          r_rem   <= w_borrow ? w_remShift[NUM_SIZE-1:0] : w_diff[NUM_SIZE-1:0];
          r_quot  <= {r_quot[NUM_SIZE-2:0], ~w_borrow};
          r_count <= r_count + CNT_ONE;
        end
        FIX: begin
          if (!r_fixPhase) begin
            r_quot     <= r_negQ ? (~r_quot + ONE) : r_quot;
            r_rem      <= r_negR ? (~r_rem + ONE) : r_rem;
            r_fixPhase <= 1'b1;
          end else begin
            r_result   <= w_selected;
            r_fixPhase <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule
